// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-stage controller: FSM state encoding,
// default widths/timeout, and the load/store decode helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;

    // A store wins when both MWE and Mux are set, so only Mux-without-MWE is a load.
    function automatic logic is_load(input logic mwe, input logic mux);
        return mux & ~mwe;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr
// Counts REQ cycles without an acknowledge and flags the last allowed cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - force the count to zero (held while not requesting)
//   enable    - count one more waiting cycle
//   expire    - count has reached TIMEOUT-1: this is the final REQ cycle
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    // Saturates at TIMEOUT so a stuck enable can never wrap back to a
    // value that looks like a fresh request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory pipeline stage: issues loads/stores to a multi-cycle data memory
// over a req/ack handshake, stalls upstream while an access is in flight,
// and drives the MEM->WB register.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   MWEi, Muxi, RWEi    - store request, load select, reg write enable (EX->MEM)
//   Resi, DATA_Bi       - ALU result / memory address, store data
//   C_Regi              - destination register index
//   stall               - hold EX->MEM and everything upstream
//   mem_req/we/addr/wdata - registered memory request
//   mem_rdata, mem_ack  - memory read data and 1-cycle completion pulse
//   RWEo, WB_Data, C_Rego - to MEM->WB register
//   mem_err             - 1-cycle pulse when an access is aborted on timeout
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access in flight; non-memory ops pass straight through
// REQ   | mem_req held, waiting for mem_ack or timeout
// DONE  | access finished; one writeback cycle, then back to IDLE
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MWEi,
    input  logic              Muxi,
    input  logic              RWEi,
    input  logic [DATA_W-1:0] Resi,
    input  logic [DATA_W-1:0] DATA_Bi,
    input  logic [REG_W-1:0]  C_Regi,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              RWEo,
    output logic [DATA_W-1:0] WB_Data,
    output logic [REG_W-1:0]  C_Rego,
    output logic              mem_err
);

    state_t            state_q, state_d;
    logic              mem_op;
    logic              expire;
    logic [DATA_W-1:0] rd_q;
    logic              err_q;

    assign mem_op = MWEi | Muxi;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_REQ),
        .enable ((state_q == ST_REQ) && !mem_ack),
        .expire (expire)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MWEi;
                        mem_addr  <= Resi;
                        mem_wdata <= DATA_Bi;
                    end
                end
                ST_REQ: begin
                    // An ack in the timeout cycle still counts as success.
                    if (mem_ack) begin
                        rd_q    <= mem_rdata;
                        mem_req <= 1'b0;
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        mem_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op) state_d = ST_REQ;
            ST_REQ:  if (mem_ack || expire) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output mux. Bubbles (RWEo=0) while stalled keep the never-stalled
    // MEM->WB register from writing the same instruction twice.
    always_comb begin
        stall   = 1'b0;
        RWEo    = 1'b0;
        WB_Data = Resi;
        C_Rego  = C_Regi;
        if (rst) begin
            WB_Data = '0;
            C_Rego  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall = mem_op;
                    RWEo  = RWEi & ~mem_op;
                end
                ST_REQ: begin
                    stall = 1'b1;
                end
                ST_DONE: begin
                    RWEo = RWEi & ~err_q;
                    if (is_load(MWEi, Muxi)) begin
                        WB_Data = rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
